div_ctrl: RTL and testbench
===========================

Name: div_ctrl

Overview:
- Sequences the iterative radix-2 restoring divider for DIV/DIVU in the Execute stage.
- Takes a divide request from the E-stage master pipe and latches the operands.
- Runs one quotient bit per cycle and returns quotient (LO) and remainder (HI).
- Drives E_div_stall, which the hazard unit uses to freeze F/D/E/M/W while a divide is in flight; a cancel input aborts it on exception flush.

Parameters:
- WIDTH, 32, operand/result width; iteration counter is clog2(WIDTH)+1 bits.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- E_div_en  in  1  DIV/DIVU instruction valid in E stage
- E_div_signed  in  1  1=DIV (signed), 0=DIVU
- E_div_opa  in  WIDTH  dividend (rs)
- E_div_opb  in  WIDTH  divisor (rt)
- div_cancel  in  1  abort request (driven by M_except)
- E_div_stall  out  1  pipeline stall request
- div_ready  out  1  one-cycle pulse, results valid
- div_lo  out  WIDTH  quotient
- div_hi  out  WIDTH  remainder

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on resetn.
- Reset (resetn=0 at posedge): state=IDLE, counter=0, div_lo=0, div_hi=0, div_ready=0. E_div_stall is then 0 unless E_div_en=1 and div_cancel=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - E_div_stall = E_div_en & ~div_cancel (combinational).
  - On E_div_en & ~div_cancel: latch |opa|, |opb| (absolute values only when E_div_signed), sign_q=opa[W-1]^opb[W-1], sign_r=opa[W-1] (both signed only); clear partial remainder; counter=0; go RUN.
  - If opb==0, go straight to DONE instead, with q=all-ones and r=opa unmodified (defined divide-by-zero result).
- RUN:
  - E_div_stall=1.
  - Each cycle: shift {rem,quo} left 1; trial = rem - |opb| over WIDTH+1 bits; if non-negative, rem=trial and quo[0]=1; counter++.
  - After the WIDTH-th iteration (counter==WIDTH-1 at edge), go DONE.
- DONE:
  - E_div_stall=0; div_ready=1 for exactly this cycle.
  - div_lo = sign_q ? -quo : quo; div_hi = sign_r ? -rem : rem (registered on entry to DONE, held until the next divide completes).
  - Next state IDLE unconditionally. E_div_en still high this cycle is the same instruction advancing and is not re-issued.
- Latency (normal): issue cycle + WIDTH RUN cycles stalled, then DONE. For WIDTH=32, E_div_stall is high for 33 consecutive cycles, div_ready occurs in cycle 34.
- Latency (divide-by-zero / early-out): stall for 1 cycle, div_ready in cycle 2.
- Signed edge case: 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0 (two's-complement wrap, no trap).
- div_cancel:
  - In RUN or DONE: next state IDLE, div_ready forced 0, div_lo/div_hi unchanged; E_div_stall deasserts the cycle after cancel.
  - Cancel in IDLE blocks issue that cycle.
- Reset mid-RUN: returns to IDLE, outputs cleared, no div_ready.
- Results update only on completed divides.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: at issue, if |opa| < |opb| (and opb!=0), go directly to DONE with q=0, r=|opa|, with signs applied as normal (1-cycle stall).
- Undefined: such operands take the full WIDTH iterations and produce identical results.

Test Plan:
- DIVU 100/7 after reset -> E_div_stall high 33 cycles, div_ready in cycle 34, div_lo=14, div_hi=2.
- DIV -100/7 (0xFFFFFF9C, 7) -> div_lo=0xFFFFFFF2 (-14), div_hi=0xFFFFFFFE (-2); DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> stall 1 cycle, div_ready cycle 2, lo=0xFFFFFFFF, hi=5.
- Start DIVU 100/7, assert div_cancel in RUN cycle 10 -> stall low next cycle, no div_ready, lo/hi keep prior values; new DIVU 9/3 then completes with lo=3, hi=0.
- resetn=0 in RUN cycle 5 -> stall 0, lo=hi=0, div_ready never pulses.
- With DIV_EARLY_OUT_EN: DIVU 3/10 -> stall 1 cycle, lo=0, hi=3. Without the macro: 33-cycle stall, same result.

Source files
------------

// File: rtl/div_ctrl_if.sv
// Handshake/result bundle between the E-stage pipe (master) and the divide sequencer (slave).
interface div_ctrl_if #(parameter int WIDTH = 32);
  logic             E_div_en;
  logic             E_div_signed;
  logic [WIDTH-1:0] E_div_opa;
  logic [WIDTH-1:0] E_div_opb;
  logic             div_cancel;
  logic             E_div_stall;
  logic             div_ready;
  logic [WIDTH-1:0] div_lo;
  logic [WIDTH-1:0] div_hi;

  modport master (
    output E_div_en, E_div_signed, E_div_opa, E_div_opb, div_cancel,
    input  E_div_stall, div_ready, div_lo, div_hi
  );

  modport slave (
    input  E_div_en, E_div_signed, E_div_opa, E_div_opb, div_cancel,
    output E_div_stall, div_ready, div_lo, div_hi
  );
endinterface

// File: rtl/div_ctrl.sv
// Radix-2 restoring divide sequencer for DIV/DIVU: one quotient bit per cycle, stalls the pipe meanwhile.
// Optional macro DIV_EARLY_OUT_EN: finish at issue when |opa| < |opb|.
//
// state  | meaning
// S_IDLE | waiting for E_div_en; stall follows the request combinationally
// S_RUN  | iterating, one quotient bit per cycle, pipe frozen
// S_DONE | results valid on div_lo/div_hi, div_ready pulses
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  div_ctrl_if.slave  div_if
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             issue, last_iter;
  logic             stall, ready;

  always_comb begin
    abs_a = (div_if.E_div_signed && div_if.E_div_opa[WIDTH-1]) ? -div_if.E_div_opa : div_if.E_div_opa;
    abs_b = (div_if.E_div_signed && div_if.E_div_opb[WIDTH-1]) ? -div_if.E_div_opb : div_if.E_div_opb;
  end

  // Trial subtraction over WIDTH+1 bits: the top bit is the borrow, i.e. "does not fit".
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
    end
  end

  assign issue     = div_if.E_div_en & ~div_if.div_cancel;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    stall   = 1'b0;
    ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall = issue;
        if (issue) begin
          qneg_d = div_if.E_div_signed & (div_if.E_div_opa[WIDTH-1] ^ div_if.E_div_opb[WIDTH-1]);
          rneg_d = div_if.E_div_signed & div_if.E_div_opa[WIDTH-1];
          rem_d  = '0;
          quo_d  = abs_a;
          dvs_d  = abs_b;
          cnt_d  = '0;
          if (div_if.E_div_opb == '0) begin
            lo_d    = '1;
            hi_d    = div_if.E_div_opa;
            state_d = S_DONE;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs_a < abs_b) begin
            // Quotient is zero and the remainder is the dividend itself, sign included.
            lo_d    = '0;
            hi_d    = div_if.E_div_opa;
            state_d = S_DONE;
          end
`endif
          else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        stall = 1'b1;
        if (div_if.div_cancel) begin
          state_d = S_IDLE;
        end else begin
          rem_d = rem_nxt;
          quo_d = quo_nxt;
          cnt_d = cnt_q + CW'(1);
          if (last_iter) begin
            lo_d    = qneg_q ? -quo_nxt : quo_nxt;
            hi_d    = rneg_q ? -rem_nxt : rem_nxt;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        ready   = ~div_if.div_cancel;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign div_if.E_div_stall = stall;
  assign div_if.div_ready   = ready;
  assign div_if.div_lo      = lo_q;
  assign div_if.div_hi      = hi_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: directed cases plus random divides, every output checked each cycle against an arithmetic model.
module tb_div_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  div_ctrl_if #(.WIDTH(W)) dif ();
  div_ctrl #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .div_if(dif));

  int n_checks = 0;
  int n_pass   = 0;

  logic         chk_en = 1'b0;
  logic         exp_stall, exp_ready;
  logic [W-1:0] exp_lo, exp_hi;
  logic [W-1:0] cur_lo, cur_hi;
  int           stall_run = 0;
  int           last_stall_len = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
  endtask

  // Reference: exact integer division on 64-bit values, truncating toward zero.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb, qq, rr;
    if (b == '0) begin
      q = '1;
      r = a;
      return;
    end
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    qq = sa / sb;
    rr = sa % sb;
    q  = qq[W-1:0];
    r  = rr[W-1:0];
  endfunction

  function automatic int calc_lat(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    longint sa, sb;
    if (b == '0) return 1;
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
`ifdef DIV_EARLY_OUT_EN
    if (sa < sb) return 1;
`endif
    return W + 1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, dif.E_div_stall}, {31'd0, exp_stall});
      chk("ready", {31'd0, dif.div_ready}, {31'd0, exp_ready});
      chk("lo", dif.div_lo, exp_lo);
      chk("hi", dif.div_hi, exp_hi);
    end
    if (dif.E_div_stall === 1'b1) stall_run++;
    else if (stall_run != 0) begin
      last_stall_len = stall_run;
      stall_run = 0;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_stall = 1'b0;
    exp_ready = 1'b0;
    exp_lo    = cur_lo;
    exp_hi    = cur_hi;
  endtask

  // Issue one divide; cancel_at>0 cancels in that RUN cycle, rst_at>0 pulls resetn there.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn,
                        input int cancel_at, input int rst_at);
    logic [W-1:0] eq, er;
    int lat;
    ref_div(a, b, sgn, eq, er);
    lat = calc_lat(a, b, sgn);
    for (int k = 0; k <= lat; k++) begin
      dif.E_div_en     = 1'b1;
      dif.E_div_signed = sgn;
      dif.E_div_opa    = a;
      dif.E_div_opb    = b;
      dif.div_cancel   = (cancel_at != 0 && k == cancel_at);
      if (rst_at != 0 && k == rst_at) resetn = 1'b0;
      exp_stall = (k < lat);
      exp_ready = (k == lat);
      if (k == lat) begin
        cur_lo = eq;
        cur_hi = er;
      end
      exp_lo = cur_lo;
      exp_hi = cur_hi;
      cycle();
      if ((cancel_at != 0 && k == cancel_at) || (rst_at != 0 && k == rst_at)) break;
    end
    dif.E_div_en   = 1'b0;
    dif.div_cancel = 1'b0;
    if (rst_at != 0) begin
      cur_lo = '0;
      cur_hi = '0;
      set_idle_exp();
      cycle();
      cycle();
      resetn = 1'b1;
    end
    set_idle_exp();
    cycle();
  endtask

  initial begin
    logic [W-1:0] q, r, a, b;
    bit sgn;
    int lat, sel, cz;

    resetn = 1'b0;
    dif.E_div_en = 1'b0;
    dif.E_div_signed = 1'b0;
    dif.E_div_opa = '0;
    dif.E_div_opb = '0;
    dif.div_cancel = 1'b0;
    cur_lo = '0;
    cur_hi = '0;
    set_idle_exp();
    cycle();
    cycle();
    chk_en = 1'b1;
    cycle();
    resetn = 1'b1;
    cycle();

    ref_div(32'd100, 32'd7, 1'b0, q, r);
    chk("model_q_100_7", q, 32'd14);
    chk("model_r_100_7", r, 32'd2);
    ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r);
    chk("model_q_min_m1", q, 32'h8000_0000);
    chk("model_r_min_m1", r, 32'd0);

    run_op(32'd100, 32'd7, 1'b0, 0, 0);
    chk("lo_100_7", dif.div_lo, 32'd14);
    chk("hi_100_7", dif.div_hi, 32'd2);
    chk("stall_len_100_7", 32'(last_stall_len), 32'd33);

    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 0, 0);
    chk("lo_m100_7", dif.div_lo, 32'hFFFF_FFF2);
    chk("hi_m100_7", dif.div_hi, 32'hFFFF_FFFE);

    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
    chk("lo_min_m1", dif.div_lo, 32'h8000_0000);
    chk("hi_min_m1", dif.div_hi, 32'd0);

    run_op(32'd5, 32'd0, 1'b0, 0, 0);
    chk("lo_5_0", dif.div_lo, 32'hFFFF_FFFF);
    chk("hi_5_0", dif.div_hi, 32'd5);
    chk("stall_len_5_0", 32'(last_stall_len), 32'd1);

    run_op(32'd100, 32'd7, 1'b0, 10, 0);
    chk("lo_after_cancel", dif.div_lo, 32'hFFFF_FFFF);
    chk("hi_after_cancel", dif.div_hi, 32'd5);
    run_op(32'd9, 32'd3, 1'b0, 0, 0);
    chk("lo_9_3", dif.div_lo, 32'd3);
    chk("hi_9_3", dif.div_hi, 32'd0);

    run_op(32'd100, 32'd7, 1'b0, 0, 5);
    chk("lo_after_reset", dif.div_lo, 32'd0);
    chk("hi_after_reset", dif.div_hi, 32'd0);

    run_op(32'd3, 32'd10, 1'b0, 0, 0);
    chk("lo_3_10", dif.div_lo, 32'd0);
    chk("hi_3_10", dif.div_hi, 32'd3);
`ifdef DIV_EARLY_OUT_EN
    chk("stall_len_3_10", 32'(last_stall_len), 32'd1);
`else
    chk("stall_len_3_10", 32'(last_stall_len), 32'd33);
`endif

    for (int i = 0; i < 60; i++) begin
      cz = $urandom_range(0, 3);
      for (int g = 0; g < cz; g++) begin
        dif.E_div_en   = ($urandom_range(0, 1) == 1);
        dif.E_div_opa  = $urandom;
        dif.E_div_opb  = $urandom;
        dif.div_cancel = dif.E_div_en;
        set_idle_exp();
        cycle();
      end
      dif.E_div_en   = 1'b0;
      dif.div_cancel = 1'b0;

      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = '0;
        1, 2, 3: b = W'($urandom_range(1, 15));
        4:       b = '1;
        default: b = $urandom;
      endcase
      a   = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      if ($urandom_range(0, 3) == 0) a = W'($urandom_range(0, 20));
      sgn = ($urandom_range(0, 1) == 1);
      lat = calc_lat(a, b, sgn);
      if (lat > 1 && $urandom_range(0, 4) == 0)
        run_op(a, b, sgn, $urandom_range(1, lat - 1), 0);
      else
        run_op(a, b, sgn, 0, 0);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
